// File: rtl/sd_pkg.sv
// sd_pkg: shared types and defaults for the sigma-delta sweep path.
// Keeps the modulator and its sweep controller agreeing on widths.
package sd_pkg;

   localparam int SD_BITWIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RUN,
      ST_DONE
   } sd_sweep_state_t;

endpackage

// File: rtl/sd_dwell_counter.sv
// sd_dwell_counter: loadable down-counter, tc_o high on the last count.
// Load wins over decrement; the count parks at zero when exhausted.
module sd_dwell_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // next count: reload, else decrement while enabled and non-zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // count register
   always_ff @(posedge clk_i) begin
      if (reset_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/sd_sweep_ctrl.sv
// sd_sweep_ctrl: settles the modulator in reset, then steps kin through
// kstart + i*kstep, dwelling a fixed number of cycles per tone.
module sd_sweep_ctrl
   import sd_pkg::*;
#(
   parameter int BITWIDTH      = SD_BITWIDTH,
   parameter int CNTW          = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [BITWIDTH-1:0] cfg_kstart,
   input  logic [BITWIDTH-1:0] cfg_kstep,
   input  logic [CNTW-1:0]     cfg_nsteps,
   input  logic [CNTW-1:0]     cfg_dwell,
   input  logic                abort,
   output logic [BITWIDTH-1:0] kin,
   output logic                sd_reset,
   output logic                busy,
   output logic                done,
   output logic [CNTW-1:0]     step_idx
);

   sd_sweep_state_t state_q, state_d;

   logic [BITWIDTH-1:0] kin_q, kin_d;
   logic [BITWIDTH-1:0] kstep_q, kstep_d;
   logic [CNTW-1:0]     nsteps_q, nsteps_d;
   logic [CNTW-1:0]     dwell_q, dwell_d;
   logic [CNTW-1:0]     step_q, step_d;
   logic                sdr_q, sdr_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic set_ld, set_tc;
   logic dw_ld, dw_tc;

   sd_dwell_counter #(.W(CNTW)) u_settle (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (set_ld),
      .load_val_i (CNTW'(SETTLE_CYCLES)),
      .en_i       (state_q == ST_SETTLE),
      .tc_o       (set_tc)
   );

   sd_dwell_counter #(.W(CNTW)) u_dwell (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (dw_ld),
      .load_val_i (dwell_q),
      .en_i       (state_q == ST_RUN),
      .tc_o       (dw_tc)
   );

   // sweep FSM: next state and next values of every registered output
   always_comb begin
      state_d  = state_q;
      kin_d    = kin_q;
      kstep_d  = kstep_q;
      nsteps_d = nsteps_q;
      dwell_d  = dwell_q;
      step_d   = step_q;
      sdr_d    = sdr_q;
      rdy_d    = rdy_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      set_ld   = 1'b0;
      dw_ld    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid && rdy_q) begin
               kstep_d  = cfg_kstep;
               nsteps_d = (cfg_nsteps == '0) ? CNTW'(1) : cfg_nsteps;
               dwell_d  = (cfg_dwell == '0) ? CNTW'(1) : cfg_dwell;
               kin_d    = cfg_kstart;
               step_d   = '0;
               set_ld   = 1'b1;
               sdr_d    = 1'b1;
               rdy_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE, ST_RUN: begin
            if (abort) begin
               kin_d   = '0;
               step_d  = '0;
               sdr_d   = 1'b1;
               rdy_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (state_q == ST_SETTLE) begin
               if (set_tc) begin
                  dw_ld   = 1'b1;
                  sdr_d   = 1'b0;
                  state_d = ST_RUN;
               end
            end else if (dw_tc) begin
               if (step_q == nsteps_q - CNTW'(1)) begin
                  kin_d   = '0;
                  sdr_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  kin_d  = kin_q + kstep_q;
                  step_d = step_q + CNTW'(1);
                  dw_ld  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         kin_q    <= '0;
         kstep_q  <= '0;
         nsteps_q <= CNTW'(1);
         dwell_q  <= CNTW'(1);
         step_q   <= '0;
         sdr_q    <= 1'b1;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         kin_q    <= kin_d;
         kstep_q  <= kstep_d;
         nsteps_q <= nsteps_d;
         dwell_q  <= dwell_d;
         step_q   <= step_d;
         sdr_q    <= sdr_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign kin       = kin_q;
   assign sd_reset  = sdr_q;
   assign cfg_ready = rdy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step_idx  = step_q;

endmodule

// File: doc/sd_sweep_ctrl.md
# sd_sweep_ctrl

Sweep sequencer for the two-piece sigma-delta modulator. It accepts a tone-sweep configuration through a valid/ready handshake and drives the modulator's `kin` control word and `reset` input. For each sweep it holds the modulator in reset for a settle period, then steps `kin` through a programmed arithmetic sequence. Each tone dwells for a programmed number of cycles. It sits directly upstream of the modulator top; its `kin` and `sd_reset` outputs connect straight to the modulator's `kin` and `reset`.

## Interface

Parameters:

- `BITWIDTH`, 32: width of the `kin` control word; must match the modulator.
- `CNTW`, 16: width of the step and dwell counters.
- `SETTLE_CYCLES`, 4: cycles the modulator is held in reset after a configuration is accepted; must be ≥1.

Ports:

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted (IDLE only).
- `cfg_kstart`  in  BITWIDTH  first `kin` value.
- `cfg_kstep`  in  BITWIDTH  two's-complement increment per tone.
- `cfg_nsteps`  in  CNTW  number of tones; 0 is treated as 1.
- `cfg_dwell`  in  CNTW  cycles per tone; 0 is treated as 1.
- `abort`  in  1  terminate the sweep.
- `kin`  out  BITWIDTH  control word to the modulator.
- `sd_reset`  out  1  reset to the modulator.
- `busy`  out  1  high in SETTLE and RUN.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `step_idx`  out  CNTW  index of the current tone, starting at 0.

## Operation

- All outputs are registered. Reset values: `kin`=0, `sd_reset`=1, `cfg_ready`=1, `busy`=0, `done`=0, `step_idx`=0. Reset also puts the FSM in IDLE.
- Reset mid-sweep: the block returns to IDLE on the next edge. No `done` pulse is produced.
- FSM states are IDLE, SETTLE, RUN and DONE.
- IDLE
  - `cfg_ready`=1, `sd_reset`=1, `kin`=0.
  - On `cfg_valid & cfg_ready`: latch all cfg fields (0→1 substitution applied at latch time), set `kin`=`cfg_kstart` and `step_idx`=0, load the settle counter, go to SETTLE.
- SETTLE
  - `sd_reset`=1; `kin` holds `kstart`.
  - After exactly `SETTLE_CYCLES` cycles, go to RUN and load the dwell counter.
- RUN
  - `sd_reset`=0.
  - When the dwell counter expires and `step_idx` == `nsteps`−1: go to DONE.
  - When it expires otherwise: `kin` ← `kin`+`kstep` (mod 2^BITWIDTH; wrap-around is legal), `step_idx`++, reload dwell.
  - The modulator is NOT reset between tones, so the modulator state carries continuously across tones.
- DONE
  - Lasts one cycle: `done`=1, `sd_reset`=1, `kin`=0.
  - Then go to IDLE.
- `abort` in SETTLE or RUN: IDLE on the next edge, with `sd_reset`=1 and `kin`=0, and no `done` pulse. `abort` is ignored in IDLE and DONE.
- `cfg_valid` while `busy`: ignored (`cfg_ready`=0). No queuing.
- Simultaneous `abort` and dwell expiry on the last tone: `abort` wins and no `done` pulse is produced.

## Timing

- Handshake accepted at edge t:
  - cycles t+1 … t+`SETTLE_CYCLES`: SETTLE.
  - from cycle t+1+`SETTLE_CYCLES`: RUN.
- Tone i occupies exactly `dwell` consecutive RUN cycles with `kin`=`kstart`+i·`kstep`.
- Total RUN length is `nsteps`·`dwell` cycles.
- `done` is high in the cycle immediately after the last RUN cycle.
- `cfg_ready` returns high one cycle after `done`.
- Minimum sweep-to-sweep spacing: `SETTLE_CYCLES` + `nsteps`·`dwell` + 2 cycles.

## Structure

- Shared package `sd_pkg` holds:
  - the FSM state encoding `sd_sweep_state_t` (IDLE, SETTLE, RUN, DONE);
  - the default `BITWIDTH`, so the modulator and the controller agree.
- One sub-module: `sd_dwell_counter`, a loadable down-counter with a terminal-count flag. It is instantiated twice: once for settle and once for dwell.
- Step accumulation, the adder and the FSM live in the top module.

## Test plan

- **Basic sweep.** `SETTLE_CYCLES`=4; accept at cycle 0 with `kstart`=0x1000, `kstep`=0x100, `nsteps`=3, `dwell`=5.
  - `sd_reset`=1 cycles 1–4.
  - `kin`=0x1000 cycles 1–9, 0x1100 cycles 10–14, 0x1200 cycles 15–19.
  - `done`=1 at cycle 20; `cfg_ready`=1 at cycle 21.
- **Wrap and negative step.**
  - `kstart`=0xFFFFFF00, `kstep`=0x200, `nsteps`=2 → second tone `kin`=0x00000100.
  - `kstep`=0xFFFFFF00 from 0x1000 → tones 0x1000, 0x0F00, 0x0E00.
- **Zero fields.** `nsteps`=0, `dwell`=0 → exactly one RUN cycle with `kin`=`kstart`, then `done`.
- **Abort.** Assert `abort` in the 2nd cycle of tone 1 → next cycle IDLE, `sd_reset`=1, `kin`=0, no `done` pulse. `abort` coincident with final dwell expiry → no `done` pulse.
- **Busy handshake.** `cfg_valid` held high throughout a sweep → `cfg_ready`=0 while `busy`. The second config is accepted only in the IDLE cycle after `done`.
- **Reset mid-run.** `reset` pulsed during RUN → all outputs take their reset values on the next cycle. A subsequent sweep runs normally.
